// File: rtl/label_rx_checker.sv
// rtl/label_rx_checker.sv - UART label receiver with label FIFO and accuracy counters
// Deserialises 8N1 label bytes at 16x oversampling and scores them against classifier results.
module label_rx_checker #(
   parameter int FIFO_AWIDTH = 4,
   parameter int MAX_COUNT   = 100,
   parameter int CNT_W       = 8
) (
   input  logic             clk_25m,
   input  logic             rst_n,
   input  logic             rx,
   input  logic             b_tick,
   input  logic             result_valid,
   input  logic [3:0]       final_number,
   output logic [CNT_W-1:0] correct_cnt,
   output logic [CNT_W-1:0] total_cnt,
   output logic             done,
   output logic             frame_err,
   output logic             overflow,
   output logic             miss,
   output logic             label_empty
);
   localparam int               DEPTH = 1 << FIFO_AWIDTH;
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   logic       rx_meta;
   logic       rx_s;
   rx_state_t  state;
   rx_state_t  state_nxt;
   logic [3:0] s;
   logic [3:0] s_nxt;
   logic [2:0] n;
   logic [2:0] n_nxt;
   logic [7:0] shreg;
   logic [7:0] shreg_nxt;
   logic       byte_done;
   logic       stop_bad;

   always_ff @(posedge clk_25m) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk_25m) begin
      if (!rst_n) begin
         state <= IDLE;
         s     <= 4'd0;
         n     <= 3'd0;
         shreg <= 8'd0;
      end else begin
         state <= state_nxt;
         s     <= s_nxt;
         n     <= n_nxt;
         shreg <= shreg_nxt;
      end
   end

   // Start is confirmed at mid start-bit; data and stop are sampled 16 ticks apart from there.
   always_comb begin
      state_nxt = state;
      s_nxt     = s;
      n_nxt     = n;
      shreg_nxt = shreg;
      byte_done = 1'b0;
      stop_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nxt = START;
               s_nxt     = 4'd0;
            end
         end
         START: begin
            if (b_tick) begin
               if (s == 4'd7) begin
                  if (!rx_s) begin
                     state_nxt = DATA;
                     s_nxt     = 4'd0;
                     n_nxt     = 3'd0;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  s_nxt = s + 4'd1;
               end
            end
         end
         DATA: begin
            if (b_tick) begin
               if (s == 4'd15) begin
                  s_nxt     = 4'd0;
                  shreg_nxt = {rx_s, shreg[7:1]};
                  if (n == 3'd7) begin
                     state_nxt = STOP;
                  end else begin
                     n_nxt = n + 3'd1;
                  end
               end else begin
                  s_nxt = s + 4'd1;
               end
            end
         end
         STOP: begin
            if (b_tick) begin
               if (s == 4'd15) begin
                  if (rx_s) begin
                     byte_done = 1'b1;
                  end else begin
                     stop_bad = 1'b1;
                  end
                  state_nxt = IDLE;
               end else begin
                  s_nxt = s + 4'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   logic [3:0]             mem [DEPTH];
   logic [FIFO_AWIDTH:0]   wr_ptr;
   logic [FIFO_AWIDTH:0]   rd_ptr;
   logic [FIFO_AWIDTH:0]   wr_ptr_nxt;
   logic [FIFO_AWIDTH:0]   rd_ptr_nxt;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic                   is_label;
   logic                   do_cmp;
   logic                   do_rd;
   logic                   do_wr;
   logic                   drop;
   logic [3:0]             head;
   logic [CNT_W-1:0]       total_nxt;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[FIFO_AWIDTH] != rd_ptr[FIFO_AWIDTH]) &&
                       (wr_ptr[FIFO_AWIDTH-1:0] == rd_ptr[FIFO_AWIDTH-1:0]);
   assign head       = mem[rd_ptr[FIFO_AWIDTH-1:0]];

   // Bytes with a nonzero upper nibble are host control bytes, never labels.
   assign is_label   = byte_done && (shreg[7:4] == 4'd0);
   assign do_cmp     = result_valid && !done;
   assign do_rd      = do_cmp && !fifo_empty;
   assign do_wr      = is_label && (!fifo_full || do_rd);
   assign drop       = is_label && fifo_full && !do_rd;

   assign wr_ptr_nxt = wr_ptr + {{FIFO_AWIDTH{1'b0}}, do_wr};
   assign rd_ptr_nxt = rd_ptr + {{FIFO_AWIDTH{1'b0}}, do_rd};
   assign total_nxt  = total_cnt + {{(CNT_W-1){1'b0}}, do_rd};

   // When full, the write lands on the slot being popped; the head was already read combinationally.
   always_ff @(posedge clk_25m) begin
      if (do_wr) begin
         mem[wr_ptr[FIFO_AWIDTH-1:0]] <= shreg[3:0];
      end
   end

   always_ff @(posedge clk_25m) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         label_empty <= 1'b1;
         total_cnt   <= '0;
         correct_cnt <= '0;
         done        <= 1'b0;
         frame_err   <= 1'b0;
         overflow    <= 1'b0;
         miss        <= 1'b0;
      end else begin
         wr_ptr      <= wr_ptr_nxt;
         rd_ptr      <= rd_ptr_nxt;
         label_empty <= (wr_ptr_nxt == rd_ptr_nxt);
         total_cnt   <= total_nxt;
         if (do_rd && (head == final_number)) begin
            correct_cnt <= correct_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         done <= (total_nxt == MAX_C);
         if (stop_bad) begin
            frame_err <= 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         if (do_cmp && fifo_empty) begin
            miss <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_label_rx_checker.sv
// tb/tb_label_rx_checker.sv - scoreboard bench for label_rx_checker
// A queue-based label model predicts counters and flags after every result pulse or probe.
module tb_label_rx_checker;
   localparam int DEPTH = 16;
   localparam int MAXC  = 100;

   logic       clk_25m      = 1'b0;
   logic       rst_n        = 1'b0;
   logic       rx           = 1'b1;
   logic       b_tick       = 1'b0;
   logic       result_valid = 1'b0;
   logic [3:0] final_number = 4'd0;
   logic [7:0] correct_cnt;
   logic [7:0] total_cnt;
   logic       done;
   logic       frame_err;
   logic       overflow;
   logic       miss;
   logic       label_empty;

   typedef struct packed {
      logic [7:0] total;
      logic [7:0] correct;
      logic       done;
      logic       ferr;
      logic       ovf;
      logic       miss;
      logic       empty;
   } snap_t;

   snap_t      exp_q[$];
   string      tag_q[$];
   int         n_vec    = 0;
   int         n_bad    = 0;
   int         tick_div = 1;
   int         tick_cnt = 0;
   logic       probe    = 1'b0;
   logic       strobe_d = 1'b0;

   logic [3:0] m_q[$];
   int         m_total;
   int         m_correct;
   bit         m_done;
   bit         m_ferr;
   bit         m_ovf;
   bit         m_miss;

   label_rx_checker #(.FIFO_AWIDTH(4), .MAX_COUNT(MAXC), .CNT_W(8)) dut (
      .clk_25m      (clk_25m),
      .rst_n        (rst_n),
      .rx           (rx),
      .b_tick       (b_tick),
      .result_valid (result_valid),
      .final_number (final_number),
      .correct_cnt  (correct_cnt),
      .total_cnt    (total_cnt),
      .done         (done),
      .frame_err    (frame_err),
      .overflow     (overflow),
      .miss         (miss),
      .label_empty  (label_empty)
   );

   always #20 clk_25m = ~clk_25m;

   always @(negedge clk_25m) begin
      tick_cnt = (tick_cnt + 1) % tick_div;
      b_tick   = (tick_cnt == 0);
   end

   always @(posedge clk_25m) strobe_d <= result_valid | probe;

   always @(negedge clk_25m) begin
      if (strobe_d) begin
         snap_t act;
         snap_t e;
         string t;
         act = {total_cnt, correct_cnt, done, frame_err, overflow, miss, label_empty};
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_strobe got %h, required a queued expectation", act);
         end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (act !== e) begin
               n_bad++;
               $display("FAIL %s got tot=%0d cor=%0d done=%b ferr=%b ovf=%b miss=%b empty=%b required tot=%0d cor=%0d done=%b ferr=%b ovf=%b miss=%b empty=%b",
                        t, act.total, act.correct, act.done, act.ferr, act.ovf, act.miss, act.empty,
                        e.total, e.correct, e.done, e.ferr, e.ovf, e.miss, e.empty);
            end
         end
      end
   end

   function automatic snap_t model_snap();
      return {8'(m_total), 8'(m_correct), m_done, m_ferr, m_ovf, m_miss, (m_q.size() == 0)};
   endfunction

   function automatic void model_reset();
      m_q.delete();
      m_total = 0; m_correct = 0;
      m_done = 0; m_ferr = 0; m_ovf = 0; m_miss = 0;
   endfunction

   function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
      if (!stop_ok) m_ferr = 1;
      else if (b[7:4] == 4'd0) begin
         if (m_q.size() >= DEPTH) m_ovf = 1;
         else m_q.push_back(b[3:0]);
      end
   endfunction

   function automatic void model_rv(input logic [3:0] fn);
      logic [3:0] h;
      if (m_done) return;
      if (m_q.size() == 0) m_miss = 1;
      else begin
         h = m_q.pop_front();
         m_total++;
         if (h == fn) m_correct++;
         m_done = (m_total == MAXC);
      end
   endfunction

   function automatic void push_exp(input string tag);
      exp_q.push_back(model_snap());
      tag_q.push_back(tag);
   endfunction

   task automatic wait_clk(input int k);
      repeat (k) @(negedge clk_25m);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; rx = 1'b1; result_valid = 1'b0;
      wait_clk(2);
      rst_n = 1'b1;
      model_reset();
      wait_clk(2);
   endtask

   task automatic probe_now(input string tag);
      probe = 1'b1;
      push_exp(tag);
      wait_clk(1);
      probe = 1'b0;
      wait_clk(1);
   endtask

   task automatic pulse_rv(input logic [3:0] fn, input string tag);
      result_valid = 1'b1;
      final_number = fn;
      model_rv(fn);
      push_exp(tag);
      wait_clk(1);
      result_valid = 1'b0;
      wait_clk(2);
   endtask

   // rv_at_stop lands a result pulse on the stop-sample cycle (only meaningful with tick_div == 1).
   task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit rv_at_stop, input logic [3:0] fn);
      int bl;
      bl = 16 * tick_div;
      rx = 1'b0;
      wait_clk(bl);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clk(bl);
      end
      rx = stop_ok;
      if (rv_at_stop) begin
         wait_clk(10);
         result_valid = 1'b1;
         final_number = fn;
         model_rv(fn);
         model_byte(b, stop_ok);
         push_exp("rv_at_byte_done");
         wait_clk(1);
         result_valid = 1'b0;
         wait_clk(bl - 11);
      end else begin
         wait_clk(bl);
         model_byte(b, stop_ok);
      end
      rx = 1'b1;
      wait_clk(40 * tick_div);
   endtask

   initial begin
      logic [7:0] b;
      logic [3:0] fn;
      model_reset();
      wait_clk(3);
      do_reset();
      probe_now("reset_values");

      tick_div = 16;
      send_byte(8'h03, 1, 0, 4'd0);
      send_byte(8'h07, 1, 0, 4'd0);
      pulse_rv(4'd3, "basic_match");
      pulse_rv(4'd5, "basic_mismatch");
      probe_now("basic_final");

      do_reset();
      send_byte(8'h05, 0, 0, 4'd0);
      probe_now("frame_err");
      rx = 1'b0;
      wait_clk(100);
      rx = 1'b1;
      wait_clk(400);
      probe_now("glitch");
      tick_div = 1;

      do_reset();
      for (int rep = 0; rep < 2; rep++) begin
         for (int i = 0; i < DEPTH + 1; i++) send_byte(8'($urandom_range(0, 15)), 1, 0, 4'd0);
         probe_now("overflow_full");
         for (int i = 0; i < DEPTH; i++) pulse_rv(m_q[0], "wrap_read");
      end
      probe_now("overflow_final");

      do_reset();
      pulse_rv(4'($urandom_range(0, 15)), "miss_empty");
      do_reset();
      send_byte(8'h09, 1, 1, 4'd9);
      pulse_rv(4'd9, "after_same_cycle");

      do_reset();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) < 2) begin
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            send_byte(b, 1, 0, 4'd0);
         end else begin
            fn = (m_q.size() > 0 && $urandom_range(0, 1) == 1) ? m_q[0] : 4'($urandom_range(0, 15));
            pulse_rv(fn, "random_mix");
         end
      end
      probe_now("random_final");

      do_reset();
      send_byte(8'h2A, 1, 0, 4'd0);
      probe_now("filter_2a");
      for (int i = 0; i < MAXC + 1; i++) begin
         send_byte(8'($urandom_range(0, 15)), 1, 0, 4'd0);
         pulse_rv(m_q[0], "done_run");
      end
      probe_now("done_final");

      do_reset();
      send_byte(8'h11, 1, 0, 4'd0);
      rx = 1'b0;
      wait_clk(16);
      for (int i = 0; i < 3; i++) begin
         rx = 1'(i % 2);
         wait_clk(16);
      end
      rst_n = 1'b0;
      rx = 1'b1;
      wait_clk(1);
      rst_n = 1'b1;
      model_reset();
      wait_clk(40);
      probe_now("mid_frame_reset");
      send_byte(8'h04, 1, 0, 4'd0);
      pulse_rv(4'd4, "after_reset_rx");

      wait_clk(5);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL leftover_expectations got %0d pending, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/label_rx_checker.md
# label_rx_checker

Receive-side counterpart of the result-transmit path in the gesture recognition accelerator. A host sends one expected label byte per test sample over UART. This block deserialises those bytes with 16x oversampling, queues them in a label FIFO, and compares each queued label against the accelerator's `final_number` when a result is reported. It accumulates correct and total counts for on-board accuracy measurement and stops counting after `MAX_COUNT` results.

## Interface

Parameters:
- `FIFO_AWIDTH`, 4: label FIFO address width; depth = 2^FIFO_AWIDTH.
- `MAX_COUNT`, 100: number of compared results after which counting stops.
- `CNT_W`, 8: width of the counters; must satisfy MAX_COUNT < 2^CNT_W.

Ports:
- `clk_25m` in 1: single clock for all logic.
- `rst_n` in 1: reset, synchronous, active-low.
- `rx` in 1: asynchronous UART line, idle high; format 8N1, LSB first.
- `b_tick` in 1: one-cycle pulse at 16x the baud rate, from `baudgen`.
- `result_valid` in 1: one-cycle pulse; `final_number` is valid in the same cycle.
- `final_number` in 4: classifier output.
- `correct_cnt` out CNT_W: number of matching comparisons.
- `total_cnt` out CNT_W: number of comparisons performed.
- `done` out 1: high when `total_cnt == MAX_COUNT`.
- `frame_err` out 1: sticky; set when a stop bit is sampled low.
- `overflow` out 1: sticky; set when a byte is lost because the FIFO is full.
- `miss` out 1: sticky; set when `result_valid` arrives while the FIFO is empty.
- `label_empty` out 1: label FIFO empty flag.

## Operation

- **Reset.** While `rst_n` is low at a clock edge:
  - all counters, sticky flags and FIFO pointers clear;
  - the receive FSM goes to IDLE;
  - the synchroniser loads 1s.
- **Reset values.** `correct_cnt=0`, `total_cnt=0`, `done=0`, `frame_err=0`, `overflow=0`, `miss=0`, `label_empty=1`.
- **Synchroniser.** `rx` passes through a two-flop synchroniser to give `rx_s`.
- **Receive FSM.** A 4-bit tick counter `s` and a 3-bit bit counter `n` advance only on `b_tick` cycles.
  - IDLE: on `rx_s==0`, go to START with `s=0`.
  - START: on the tick where `s==7`, check `rx_s`. If it is 0, go to DATA with `s=0`, `n=0`. If it is 1, treat it as a glitch and return to IDLE with no flags set.
  - DATA: on the tick where `s==15`, shift `rx_s` into bit 7 of the shift register (right shift) and set `s=0`. After the 8th bit (`n==7`), go to STOP.
  - STOP: on the tick where `s==15`, sample `rx_s`. If it is 1, assert `byte_done` for one cycle. If it is 0, set `frame_err` and discard the byte. Go to IDLE in either case.
- **Label filter.**
  - A byte with upper nibble 0 is written to the FIFO as a 4-bit label.
  - A byte with nonzero upper nibble is discarded silently. Host control bytes use this range.
- **FIFO.**
  - Write when `byte_done` is high, the byte passes the filter, and the FIFO is not full. If the FIFO is full, drop the byte and set `overflow`.
  - A simultaneous read and write is legal, including when the FIFO is full: the read frees a slot in the same cycle and the write is accepted.
  - Pointers wrap modulo the depth. Full/empty are distinguished by one extra pointer bit.
- **Compare.** Applies to a `result_valid` pulse while `done==0`:
  - If the FIFO is not empty: pop the head entry, increment `total_cnt`, and increment `correct_cnt` if the head equals `final_number`.
  - If the FIFO is empty: set `miss`; counters are unchanged.
- **Done.** When `done==1`, `result_valid` is ignored: no pop, no miss. Bytes keep arriving and are queued or dropped under the normal rules.
- **Saturation.** Counters never exceed `MAX_COUNT`, and `correct_cnt <= total_cnt` always holds.

## Timing

- **Line to FSM.** 2-cycle latency from an `rx` edge to `rx_s`.
- **Start bit.** The start bit is confirmed 8 ticks after the falling edge is detected.
- **Data sampling.** Data bits are sampled at mid-bit, every 16 ticks.
- **Byte availability.** `byte_done` coincides with the stop-sample tick cycle. `label_empty` deasserts in the next cycle. A `result_valid` pulse in the same cycle as `byte_done`, with the FIFO otherwise empty, counts as a miss.
- **Compare latency.** `result_valid` in cycle N updates counters and flags at the edge ending cycle N, so they are visible in cycle N+1. `done` rises in the same cycle that `total_cnt` reaches `MAX_COUNT`.
- **Registered outputs.** All outputs are registered.

## Test plan

- **Basic match and mismatch.** Send bytes 0x03 then 0x07, then pulse `result_valid` with `final_number` = 3, then 5 (b_tick every 16 clocks, so one bit = 256 clocks).
  - Required: `total_cnt=2`, `correct_cnt=1`, `label_empty=1`, no flags set.
- **Framing error and glitch.** Send 0x05 with its stop bit driven low. Separately, apply a 100-clock low glitch on idle `rx`.
  - Required: `frame_err=1`, FIFO still empty, no byte produced by the glitch.
- **Overflow and wrap.** Send 17 labels with FIFO_AWIDTH=4, then issue 16 `result_valid` pulses with matching values. Repeat the send/compare sequence twice.
  - Required: `overflow=1`, `correct_cnt=32`, read order matches write order across pointer wrap.
- **Miss.** Issue `result_valid` with the FIFO empty.
  - Required: `miss=1`, `total_cnt=0`.
  - Also cover `result_valid` in the same cycle as `byte_done`: required `miss=1`, and the byte remains queued.
- **Done and filtering.** Send 0x2A, then 101 matching labels, with 101 `result_valid` pulses.
  - Required: 0x2A dropped, `total_cnt=correct_cnt=100`, `done=1`, one label left queued (`label_empty=0`).
- **Mid-frame reset.** Hold `rst_n` low for 1 clock during the DATA state, then send 0x04.
  - Required: all outputs at reset values; 0x04 is received cleanly afterward.
